// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake on both sides,
// a carry register for ADC/SBB chaining and multi-cycle N-bit shifts.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - input handshake; A, B, F, Cin, use_flag_c
//   out_valid/out_ready  - output handshake; Result, Status
//   busy                 - high while a multi-cycle shift is stepping
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       F,
    input  logic             Cin,
    input  logic             use_flag_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [5:0]       Status,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_res, r_sh;
    logic [5:0]       r_stat;
    logic             r_ov, r_carry;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_nop;

    logic [SHW-1:0]   w_n;
    logic             w_acc, w_isn, w_start, w_fin, w_ld, w_cin_sel;
    logic             w_arith, w_sub, w_c;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [4:0]       w_lo_s, w_lo_d;
    logic [WIDTH-1:0] w_sc_res, w_sh_nxt, w_ld_res;
    logic             w_sc_cf, w_sc_vf, w_sc_af, w_sh_out;
    logic             w_ld_cf, w_ld_vf, w_ld_af;

    assign in_ready  = (r_state == S_IDLE) && (!r_ov || out_ready);
    assign busy      = (r_state == S_EXEC);
    assign out_valid = r_ov;
    assign Result    = r_res;
    assign Status    = r_stat;

    assign w_n       = B[SHW-1:0];
    assign w_acc     = in_valid && in_ready;
    assign w_isn     = (F[4:2] == 3'b110);
    // n = 0 N-ops complete on the accept edge like any single-cycle op
    assign w_start   = w_acc && w_isn && (w_n != '0);
    assign w_fin     = (r_state == S_EXEC) && (r_cnt == CNT_ONE);
    assign w_ld      = (w_acc && !w_start) || w_fin;
    assign w_cin_sel = use_flag_c ? r_carry : Cin;

    // Operand selection for the shared adder/subtractor
    always_comb begin
        w_arith = 1'b0;
        w_sub   = 1'b0;
        w_op2   = B;
        w_c     = 1'b0;
        case (F)
            5'b00001: begin w_arith = 1'b1; w_op2 = ONE; end
            5'b00011: begin w_arith = 1'b1; w_sub = 1'b1; w_op2 = ONE; end
            5'b00100: w_arith = 1'b1;
            5'b00101: begin w_arith = 1'b1; w_c = w_cin_sel; end
            5'b00110: begin w_arith = 1'b1; w_sub = 1'b1; end
            5'b00111: begin
                w_arith = 1'b1;
                w_sub   = 1'b1;
                w_c     = w_cin_sel;
            end
            default: ;
        endcase
    end

    assign w_sum  = {1'b0, A} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_c};
    assign w_dif  = {1'b0, A} - {1'b0, w_op2} - {{WIDTH{1'b0}}, w_c};
    assign w_lo_s = {1'b0, A[3:0]} + {1'b0, w_op2[3:0]} + {4'b0, w_c};
    assign w_lo_d = {1'b0, A[3:0]} - {1'b0, w_op2[3:0]} - {4'b0, w_c};

    // Single-cycle result and flags
    always_comb begin
        w_sc_res = '0;
        w_sc_cf  = 1'b0;
        w_sc_vf  = 1'b0;
        w_sc_af  = 1'b0;
        if (w_arith) begin
            if (w_sub) begin
                w_sc_res = w_dif[WIDTH-1:0];
                w_sc_cf  = w_dif[WIDTH];
                w_sc_vf  = (A[WIDTH-1] != w_op2[WIDTH-1])
                        && (w_dif[WIDTH-1] != A[WIDTH-1]);
                w_sc_af  = w_lo_d[4];
            end else begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_cf  = w_sum[WIDTH];
                w_sc_vf  = (A[WIDTH-1] == w_op2[WIDTH-1])
                        && (w_sum[WIDTH-1] != A[WIDTH-1]);
                w_sc_af  = w_lo_s[4];
            end
        end else begin
            case (F)
                5'b01000: w_sc_res = A & B;
                5'b01001: w_sc_res = A | B;
                5'b01010: w_sc_res = A ^ B;
                5'b01011: w_sc_res = ~A;
                5'b10000, 5'b10010: begin
                    w_sc_res = {A[WIDTH-2:0], 1'b0};
                    w_sc_cf  = A[WIDTH-1];
                end
                5'b10001: begin
                    w_sc_res = {1'b0, A[WIDTH-1:1]};
                    w_sc_cf  = A[0];
                end
                5'b10011: begin
                    w_sc_res = {A[WIDTH-1], A[WIDTH-1:1]};
                    w_sc_cf  = A[0];
                end
                5'b10100: begin
                    w_sc_res = {A[WIDTH-2:0], A[WIDTH-1]};
                    w_sc_cf  = A[WIDTH-1];
                end
                5'b10101: begin
                    w_sc_res = {A[0], A[WIDTH-1:1]};
                    w_sc_cf  = A[0];
                end
                5'b10110: begin
                    w_sc_res = {A[WIDTH-2:0], Cin};
                    w_sc_cf  = A[WIDTH-1];
                end
                5'b10111: begin
                    w_sc_res = {Cin, A[WIDTH-1:1]};
                    w_sc_cf  = A[0];
                end
                5'b11000, 5'b11001, 5'b11010, 5'b11011: w_sc_res = A;
                default: ;
            endcase
        end
    end

    // One bit-step of the latched N-op
    always_comb begin
        w_sh_nxt = r_sh;
        w_sh_out = 1'b0;
        case (r_nop)
            2'b00: begin
                w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};
                w_sh_out = r_sh[WIDTH-1];
            end
            2'b01: begin
                w_sh_nxt = {1'b0, r_sh[WIDTH-1:1]};
                w_sh_out = r_sh[0];
            end
            2'b10: begin
                w_sh_nxt = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                w_sh_out = r_sh[0];
            end
            default: begin
                // rotate: the bit leaving the MSB becomes the new bit 0
                w_sh_nxt = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
                w_sh_out = r_sh[WIDTH-1];
            end
        endcase
    end

    assign w_ld_res = w_fin ? w_sh_nxt : w_sc_res;
    assign w_ld_cf  = w_fin ? w_sh_out : w_sc_cf;
    assign w_ld_vf  = w_fin ? 1'b0 : w_sc_vf;
    assign w_ld_af  = w_fin ? 1'b0 : w_sc_af;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_EXEC;
            S_EXEC: if (w_fin) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_stat  <= '0;
            r_ov    <= 1'b0;
            r_carry <= 1'b0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_nop   <= '0;
        end else begin
            if (w_ld) begin
                r_res   <= w_ld_res;
                r_stat  <= {w_ld_cf, ~|w_ld_res, w_ld_res[WIDTH-1],
                            w_ld_vf, ~^w_ld_res, w_ld_af};
                r_carry <= w_ld_cf;
                r_ov    <= 1'b1;
            end else if (r_ov && out_ready) begin
                r_ov <= 1'b0;
            end
            if (w_start) begin
                r_sh  <= A;
                r_cnt <= w_n;
                r_nop <= F[1:0];
            end else if (r_state == S_EXEC) begin
                r_sh  <= w_sh_nxt;
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe at WIDTH=16.
// Ports: none (drives clk, rst_n and all DUT inputs).
module tb_alu_pipe;

    localparam logic [4:0] OP_INC  = 5'b00001;
    localparam logic [4:0] OP_DEC  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADC  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SBB  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOT  = 5'b01011;
    localparam logic [4:0] OP_SAR  = 5'b10011;
    localparam logic [4:0] OP_ROL  = 5'b10100;
    localparam logic [4:0] OP_RCR  = 5'b10111;
    localparam logic [4:0] OP_SHLN = 5'b11000;
    localparam logic [4:0] OP_SHRN = 5'b11001;
    localparam logic [4:0] OP_SARN = 5'b11010;
    localparam logic [4:0] OP_ROLN = 5'b11011;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  F;
    logic        Cin;
    logic        use_flag_c;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Result;
    logic [5:0]  Status;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .F          (F),
        .Cin        (Cin),
        .use_flag_c (use_flag_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Status     (Status),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic c,
                         input logic u, output int lat, output int bcnt);
        int k;
        F = f; A = a; B = b; Cin = c; use_flag_c = u;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; F = OP_ADD;
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 50) begin
            if (busy && !in_ready) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic run(input string tag, input logic [4:0] f,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic u,
                       input logic [15:0] eres, input logic [5:0] est,
                       input int elat);
        int lat, bcnt;
        do_op(f, a, b, c, u, lat, bcnt);
        chk({tag, "_res"},  Result, eres);
        chk({tag, "_st"},   Status, est);
        chk({tag, "_lat"},  lat, elat);
        chk({tag, "_busy"}, bcnt, elat - 1);
    endtask

    initial begin
        int lat, bcnt;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; F = '0; Cin = 1'b0; use_flag_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov",   out_valid, 0);
        chk("rst_res",  Result, 0);
        chk("rst_st",   Status, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", in_ready, 1);
        @(posedge clk); #1;

        run("add_ov",  OP_ADD, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 6'b001101, 1);
        run("add_cy",  OP_ADD, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 6'b110011, 1);
        run("adc_reg", OP_ADC, 16'h0000, 16'h0000, 0, 1, 16'h0001, 6'b000000, 1);
        run("add_cy2", OP_ADD, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 6'b110011, 1);
        run("adc_cin", OP_ADC, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6'b010010, 1);
        run("sub_bw",  OP_SUB, 16'h0000, 16'h0001, 0, 0, 16'hFFFF, 6'b101011, 1);
        run("sbb_reg", OP_SBB, 16'h0005, 16'h0002, 0, 1, 16'h0002, 6'b000000, 1);
        run("inc",     OP_INC, 16'h000F, 16'h0000, 0, 0, 16'h0010, 6'b000001, 1);
        run("dec",     OP_DEC, 16'h8000, 16'h0000, 0, 0, 16'h7FFF, 6'b000101, 1);
        run("and",     OP_AND, 16'hF0F0, 16'hFF00, 0, 0, 16'hF000, 6'b001010, 1);
        run("not",     OP_NOT, 16'h00FF, 16'h0000, 0, 0, 16'hFF00, 6'b001010, 1);
        run("xor",     OP_XOR, 16'hA5A5, 16'hA5A5, 0, 0, 16'h0000, 6'b010010, 1);
        run("sar",     OP_SAR, 16'h8001, 16'h0000, 0, 0, 16'hC000, 6'b101010, 1);
        run("rcr",     OP_RCR, 16'h0002, 16'h0000, 1, 0, 16'h8001, 6'b001010, 1);
        run("rol",     OP_ROL, 16'h8000, 16'h0000, 0, 0, 16'h0001, 6'b100000, 1);
        run("bad",     OP_BAD, 16'h1234, 16'h5678, 0, 0, 16'h0000, 6'b010010, 1);

        run("shln4",   OP_SHLN, 16'h1001, 16'h0004, 0, 0, 16'h0010, 6'b100000, 5);
        run("shln0",   OP_SHLN, 16'h1001, 16'h0000, 0, 0, 16'h1001, 6'b000010, 1);
        run("roln1",   OP_ROLN, 16'h8001, 16'h0001, 0, 0, 16'h0003, 6'b100010, 2);
        run("sarn3",   OP_SARN, 16'h8000, 16'h0003, 0, 0, 16'hF000, 6'b001010, 4);
        run("shrn1",   OP_SHRN, 16'h0005, 16'h0001, 0, 0, 16'h0002, 6'b100000, 2);

        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op(OP_OR, 16'h0F00, 16'h00F0, 0, 0, lat, bcnt);
        chk("bp_res0", Result, 16'h0FF0);
        chk("bp_st0",  Status, 6'b000010);
        F = OP_ADD; A = 16'h0001; B = 16'h0001; Cin = 1'b0;
        use_flag_c = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_rdy", in_ready, 0);
            chk("bp_ov",  out_valid, 1);
            chk("bp_res", Result, 16'h0FF0);
            chk("bp_st",  Status, 6'b000010);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_ov",  out_valid, 1);
        chk("bp_new_res", Result, 16'h0002);
        chk("bp_new_st",  Status, 6'b000000);

        run("add_cy3", OP_ADD, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 6'b110011, 1);
        F = OP_SHLN; A = 16'h0001; B = 16'h0008; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ex_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ex_rst_ov",   out_valid, 0);
        chk("ex_rst_busy", busy, 0);
        chk("ex_rst_res",  Result, 0);
        chk("ex_rst_st",   Status, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ex_rst_rdy", in_ready, 1);
        run("adc_rst", OP_ADC, 16'h0000, 16'h0000, 0, 1, 16'h0000, 6'b010010, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 16-bit combinational ALU. The opcode map and flag set are unchanged. It adds a valid/ready handshake on input and output, a persistent carry register for multi-word ADC/SBB chaining, and multi-cycle variable-amount shift/rotate ops driven by an FSM. It sits between the datapath issue logic and the writeback stage.

Parameters:
WIDTH, 16, operand/result width; must be at least 8 and a multiple of 4.
SHW, $clog2(WIDTH), derived localparam giving the shift-amount width (B[SHW-1:0]); not overridable.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept; an op is accepted on an edge where in_valid && in_ready.
A  input  WIDTH  first operand.
B  input  WIDTH  second operand; B[SHW-1:0] is the shift amount n for N-ops.
F  input  5  opcode.
Cin  input  1  external carry/borrow.
use_flag_c  input  1  ADC/SBB carry source: 1 = stored carry register, 0 = Cin.
out_valid  output  1  Result/Status valid.
out_ready  input  1  consumer accepts; a result is consumed on an edge where out_valid && out_ready.
Result  output  WIDTH  registered result.
Status  output  6  registered flags {CF, ZF, NF, VF, PF, AF}.
busy  output  1  high while in the EXEC state.

Behaviour:
- Reset (async, rst_n low): state = IDLE; Result = 0; Status = 0; out_valid = 0; carry register = 0; busy = 0. An in-flight EXEC is aborted and produces no output. in_ready = 1 once reset is released.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This gives one op per cycle for single-cycle ops under continuous out_ready.
- Opcodes:
  - Arithmetic: 00001 INC, 00011 DEC, 00100 ADD, 00101 ADC, 00110 SUB, 00111 SBB.
  - Logic: 01000 AND, 01001 OR, 01010 XOR, 01011 NOT.
  - Single-bit shift/rotate: 10000 SHL, 10001 SHR, 10010 SAL, 10011 SAR, 10100 ROL, 10101 ROR, 10110 RCL (Cin fills bit 0), 10111 RCR (Cin fills MSB).
  - Multi-cycle N-ops (new): 11000 SHLN, 11001 SHRN, 11010 SARN, 11011 ROLN.
  - Any other code: Result = 0, Status = {0,1,0,0,1,0}.
- Single-cycle ops: computed from the accepted inputs and registered on the accept edge; out_valid is high from the next cycle (latency 1).
- N-ops FSM, IDLE -> EXEC -> IDLE:
  - Accept latches A and n. If n = 0: Result = A, CF = 0, output on the accept edge, no EXEC.
  - Otherwise EXEC performs one bit-step per cycle for n cycles; busy = 1 and in_ready = 0 throughout.
  - On the n-th step edge the output is registered, out_valid rises, and the FSM returns to IDLE. Total latency is n + 1 edges.
  - Ignored in EXEC: A, B, F, in_valid.
- Output hold: while out_valid && !out_ready, Result and Status stay stable and no new op is accepted. out_valid falls on the consume edge unless a new result loads on the same edge.
- Arithmetic width and flag rules (WIDTH+1-bit compute):
  - CF = carry out for add-type ops; for sub-type ops, CF = borrow (1 when unsigned A < B + c).
  - VF = signed overflow.
  - AF = carry/borrow out of bit 3.
  - ADC/SBB with use_flag_c = 1 read the carry register value held at the accept edge.
- Other op flags:
  - Logic: CF = VF = AF = 0.
  - Single-bit shift/rotate: CF = A[WIDTH-1] for left ops, A[0] for right ops; VF = AF = 0.
  - N-ops: CF = last bit shifted out (ROLN: final Result[0]); VF = AF = 0.
- Flags for all ops: ZF = (Result == 0); NF = Result[WIDTH-1]; PF = ~^Result.
- Carry register: loaded with CF whenever any result is registered. A back-to-back ADC therefore sees the immediately preceding op's CF.

Test Plan:
- WIDTH=16, ADD A=0x7FFF B=0x0001 -> one cycle later out_valid=1, Result=0x8000, Status=6'b001101.
- ADD 0xFFFF+0x0001 (Status=6'b110011), then the next cycle ADC A=0 B=0 use_flag_c=1 Cin=0 -> Result=0x0001, Status=6'b000000; the same ADC with use_flag_c=0 -> Result=0x0000.
- SUB A=0x0000 B=0x0001 -> Result=0xFFFF, Status=6'b101011.
- SHLN A=0x1001 B=4 -> busy=1 and in_ready=0 for 4 cycles; out_valid after 5 edges; Result=0x0010, Status=6'b100000. B=0 -> Result=0x1001 with latency 1.
- Back-pressure: out_ready=0 for 3 cycles after a result -> Result/Status unchanged, in_ready=0; out_ready=1 -> consumed, next op accepted the same cycle.
- Reset asserted at EXEC step 2 of SHLN B=8 -> out_valid=0, busy=0, Result=0, Status=0 immediately; after release, in_ready=1 and the carry register is 0 (checked via ADC use_flag_c=1 on 0+0 -> 0x0000).
